// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
// Holds the arbiter FSM state encoding and the full-word byte-enable constant
// used for instruction fetches.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DATA  = 2'd1,
    ARB_INSTR = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory bus between the
// instruction-fetch port (arb_i_*) and the exec load/store port (arb_d_*).
// Data requests win over fetch. The granted request is latched into bus
// registers on the grant edge, held until the bus acks, then the owning port
// gets a one-cycle valid pulse with read data (0 for writes).
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   arb_d_*                data port: read/write level requests, addr, wdata,
//                          byte enables in; valid pulse + rdata out
//   arb_i_*                fetch port: level request + addr in; valid + rdata out
//   arb_bus_*              memory bus: req/we/addr/wdata/be out; ack/rdata in
//   arb_err_out            watchdog timeout pulse, coincident with valid
//
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that abandons a
// bus cycle after TIMEOUT_CYCLES cycles without ack. Without it the FSM waits
// indefinitely and arb_err_out is tied to 0.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arb_d_read_en_in,
  input  logic              arb_d_write_en_in,
  input  logic [ADDR_W-1:0] arb_d_addr_in,
  input  logic [DATA_W-1:0] arb_d_wdata_in,
  input  logic [3:0]        arb_d_byte_en_in,
  output logic              arb_d_valid_out,
  output logic [DATA_W-1:0] arb_d_rdata_out,
  input  logic              arb_i_req_in,
  input  logic [ADDR_W-1:0] arb_i_addr_in,
  output logic              arb_i_valid_out,
  output logic [DATA_W-1:0] arb_i_rdata_out,
  output logic              arb_bus_req_out,
  output logic              arb_bus_we_out,
  output logic [ADDR_W-1:0] arb_bus_addr_out,
  output logic [DATA_W-1:0] arb_bus_wdata_out,
  output logic [3:0]        arb_bus_be_out,
  input  logic              arb_bus_ack_in,
  input  logic [DATA_W-1:0] arb_bus_rdata_in,
  output logic              arb_err_out
);

  arb_state_t        state_q, state_d;
  logic              owner_data_q;   // which port owns the current/last grant
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] rdata_q;

  logic data_req, busy, grant_data, grant_instr, ack_hit, timeout_hit;

  assign data_req    = arb_d_read_en_in | arb_d_write_en_in;
  assign busy        = (state_q == ARB_DATA) || (state_q == ARB_INSTR);
  assign grant_data  = (state_q == ARB_IDLE) && data_req;
  assign grant_instr = (state_q == ARB_IDLE) && !data_req && arb_i_req_in;
  // ack is only meaningful while a bus cycle is outstanding
  assign ack_hit     = busy && arb_bus_ack_in;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Fires on the last allowed wait cycle, so bus_req stays high for exactly
  // TIMEOUT_CYCLES cycles. A coincident ack wins.
  assign timeout_hit = busy && !arb_bus_ack_in &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant_data || grant_instr) cnt_q <= '0;
      else if (busy)                 cnt_q <= cnt_q + 1'b1;
      // registered on the edge into RESP, so it lines up with valid
      err_q <= timeout_hit;
    end
  end

  assign arb_err_out = err_q;
`else
  assign timeout_hit = 1'b0;
  assign arb_err_out = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (data_req)          state_d = ARB_DATA;
        else if (arb_i_req_in) state_d = ARB_INSTR;
      end
      ARB_DATA, ARB_INSTR: begin
        if (arb_bus_ack_in || timeout_hit) state_d = ARB_RESP;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Bus registers captured on the grant edge, read data captured on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_data_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
    end else begin
      if (grant_data) begin
        owner_data_q <= 1'b1;
        we_q         <= arb_d_write_en_in;  // read+write together is a write
        addr_q       <= arb_d_addr_in;
        wdata_q      <= arb_d_write_en_in ? arb_d_wdata_in : '0;
        be_q         <= arb_d_byte_en_in;
      end else if (grant_instr) begin
        owner_data_q <= 1'b0;
        we_q         <= 1'b0;
        addr_q       <= arb_i_addr_in;
        wdata_q      <= '0;
        be_q         <= BE_FULL;
      end
      if (ack_hit)          rdata_q <= we_q ? '0 : arb_bus_rdata_in;
      else if (timeout_hit) rdata_q <= '0;
    end
  end

  assign arb_bus_req_out   = busy;
  assign arb_bus_we_out    = we_q;
  assign arb_bus_addr_out  = addr_q;
  assign arb_bus_wdata_out = wdata_q;
  assign arb_bus_be_out    = be_q;

  assign arb_d_valid_out = (state_q == ARB_RESP) &&  owner_data_q;
  assign arb_i_valid_out = (state_q == ARB_RESP) && !owner_data_q;
  assign arb_d_rdata_out = rdata_q;
  assign arb_i_rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized transactions, with expectations derived from a transaction-level
// model (who is granted, what the bus must carry, what comes back, and when).
module tb_mem_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_rd = 0, d_wr = 0;
  logic [31:0] d_addr = 0, d_wdata = 0;
  logic [3:0]  d_be = 0;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        i_req = 0;
  logic [31:0] i_addr = 0;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 0;
  logic [31:0] bus_rdata = 0;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .arb_d_read_en_in(d_rd), .arb_d_write_en_in(d_wr),
    .arb_d_addr_in(d_addr), .arb_d_wdata_in(d_wdata), .arb_d_byte_en_in(d_be),
    .arb_d_valid_out(d_valid), .arb_d_rdata_out(d_rdata),
    .arb_i_req_in(i_req), .arb_i_addr_in(i_addr),
    .arb_i_valid_out(i_valid), .arb_i_rdata_out(i_rdata),
    .arb_bus_req_out(bus_req), .arb_bus_we_out(bus_we),
    .arb_bus_addr_out(bus_addr), .arb_bus_wdata_out(bus_wdata),
    .arb_bus_be_out(bus_be), .arb_bus_ack_in(bus_ack),
    .arb_bus_rdata_in(bus_rdata), .arb_err_out(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic all_outs_or();
    return |{d_valid, d_rdata, i_valid, i_rdata, bus_req, bus_we,
             bus_addr, bus_wdata, bus_be, err};
  endfunction

  // Plays the memory side of one bus transaction and checks it end to end.
  // Expected values come from the caller's view of the request: which port
  // should own the grant, whether it is a write, and what the bus must carry.
  task automatic serve(input bit is_data, input bit is_wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int dly, input logic [31:0] rd);
    int n = 0;
    logic [3:0] exp_be;
    exp_be = is_data ? be : 4'hF;
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    chk("grant_seen", {31'd0, bus_req}, 32'd1);
    chk("bus_addr", bus_addr, addr);
    chk("bus_we", {31'd0, bus_we}, {31'd0, is_wr});
    if (is_wr) chk("bus_wdata", bus_wdata, wdata);
    if (is_wr || !is_data) chk("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("bus_hold_req", {31'd0, bus_req}, 32'd1);
      chk("bus_hold_addr", bus_addr, addr);
      chk("no_early_valid", {30'd0, d_valid, i_valid}, 32'd0);
    end
    bus_ack = 1'b1;
    bus_rdata = rd;
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    chk("valid_port", {30'd0, d_valid, i_valid}, is_data ? 32'd2 : 32'd1);
    chk("rdata", is_data ? d_rdata : i_rdata, is_wr ? 32'd0 : rd);
    chk("req_drop", {31'd0, bus_req}, 32'd0);
    chk("err_quiet", {31'd0, err}, 32'd0);
  endtask

  // One IDLE gap with requests dropped; a stray ack must be ignored.
  task automatic gap(input bit stray_ack);
    d_rd = 0; d_wr = 0; i_req = 0;
    @(negedge clk);
    bus_ack = stray_ack;
    chk("gap_no_valid", {30'd0, d_valid, i_valid}, 32'd0);
    @(negedge clk);
    bus_ack = 0;
    chk("gap_idle", {29'd0, bus_req, d_valid, i_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_outs", {31'd0, all_outs_or()}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {31'd0, all_outs_or()}, 32'd0);

    // Fetch alone
    i_req = 1; i_addr = 32'h100;
    serve(0, 0, 32'h100, 0, 4'hF, 1, 32'h00500093);
    gap(0);

    // Simultaneous requests: data first, then fetch after an IDLE cycle
    d_rd = 1; d_addr = 32'h2000; d_be = 4'hF;
    i_req = 1; i_addr = 32'h104;
    serve(1, 0, 32'h2000, 0, 4'hF, 0, 32'h11112222);
    d_rd = 0;
    serve(0, 0, 32'h104, 0, 4'hF, 0, 32'h33334444);
    gap(1);

    // Store with immediate ack
    d_wr = 1; d_addr = 32'h3004; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    serve(1, 1, 32'h3004, 32'hDEADBEEF, 4'b0011, 0, 32'hFFFF0000);
    gap(0);

    // Async reset mid-transaction
    d_rd = 1; d_addr = 32'h5000;
    @(negedge clk); @(negedge clk);
    chk("pre_reset_busy", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 0;
    #1 chk("async_reset_outs", {31'd0, all_outs_or()}, 32'd0);
    d_rd = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    i_req = 1; i_addr = 32'h200;
    serve(0, 0, 32'h200, 0, 4'hF, 2, 32'hCAFEF00D);
    gap(0);

    // Back-to-back loads: drop on valid, re-raise next cycle
    d_rd = 1; d_addr = 32'h2000; d_be = 4'hF;
    serve(1, 0, 32'h2000, 0, 4'hF, 0, 32'hA5A5A5A5);
    d_rd = 0;
    @(negedge clk);
    chk("b2b_single_valid", {30'd0, d_valid, i_valid}, 32'd0);
    d_rd = 1; d_addr = 32'h2004;
    serve(1, 0, 32'h2004, 0, 4'hF, 1, 32'h5A5A5A5A);
    gap(0);

    // Randomized transactions: kind 0 fetch, 1 load, 2 store, 3 rd+wr (write),
    // 4 load racing a fetch
    for (int t = 0; t < 40; t++) begin
      int kind, dly;
      logic [31:0] a, wd, rd, ia;
      logic [3:0] be;
      kind = $urandom_range(0, 4);
      dly  = $urandom_range(0, 3);
      a = $urandom; wd = $urandom; rd = $urandom; ia = $urandom;
      be = 4'($urandom);
      case (kind)
        0: begin i_req = 1; i_addr = a; serve(0, 0, a, 0, be, dly, rd); end
        1: begin d_rd = 1; d_addr = a; d_be = be; serve(1, 0, a, 0, be, dly, rd); end
        2, 3: begin
          d_wr = 1; d_rd = (kind == 3); d_addr = a; d_wdata = wd; d_be = be;
          serve(1, 1, a, wd, be, dly, rd);
        end
        default: begin
          d_rd = 1; d_addr = a; d_be = be; i_req = 1; i_addr = ia;
          serve(1, 0, a, 0, be, dly, rd);
          d_rd = 0;
          serve(0, 0, ia, 0, 4'hF, dly, ~rd);
        end
      endcase
      gap(1'($urandom));
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog: never ack
    begin
      int hi = 0;
      int n = 0;
      d_rd = 1; d_addr = 32'h7000; d_be = 4'hF;
      @(negedge clk);
      while (!bus_req && n < 10) begin @(negedge clk); n++; end
      while (bus_req && hi < 20) begin hi++; @(negedge clk); end
      chk("tmo_req_cycles", 32'(hi), 32'd4);
      chk("tmo_valid_err", {30'd0, d_valid, err}, 32'd3);
      chk("tmo_rdata", d_rdata, 32'd0);
      gap(0);
      chk("tmo_err_once", {31'd0, err}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one single-ported memory bus between the instruction-fetch port and the exec load/store port. It accepts held-level requests, grants one requester at a time with fixed priority (data over fetch), sequences the bus transaction, and returns a one-cycle valid pulse with read data. Exec's hold flag stays asserted until that pulse, so the arbiter is the sole pacing element for loads and stores.

Parameters:
ADDR_W, 32, bus and port address width
DATA_W, 32, bus and port data width
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
arb_d_read_en_in  in  1  data-port read request (level)
arb_d_write_en_in  in  1  data-port write request (level)
arb_d_addr_in  in  32  data-port address
arb_d_wdata_in  in  32  data-port write data
arb_d_byte_en_in  in  4  data-port byte enables
arb_d_valid_out  out  1  data-port completion pulse
arb_d_rdata_out  out  32  data-port read data, valid with the pulse
arb_i_req_in  in  1  fetch read request (level)
arb_i_addr_in  in  32  fetch address
arb_i_valid_out  out  1  fetch completion pulse
arb_i_rdata_out  out  32  fetched instruction, valid with the pulse
arb_bus_req_out  out  1  bus request
arb_bus_we_out  out  1  bus write enable
arb_bus_addr_out  out  32  bus address
arb_bus_wdata_out  out  32  bus write data
arb_bus_be_out  out  4  bus byte enables
arb_bus_ack_in  in  1  bus completion, single cycle
arb_bus_rdata_in  in  32  bus read data, valid with ack
arb_err_out  out  1  timeout pulse (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. All outputs are 0. Any in-flight bus transaction is abandoned.
- FSM states:
  - IDLE: sample requests. Data request (read_en or write_en) wins over fetch; go to DATA, else to INSTR if arb_i_req_in, else stay.
  - DATA / INSTR: bus outputs come from registers captured on the grant edge. bus_req=1. Wait for ack. On ack, capture rdata and go to RESP.
  - RESP: pulse the granted port's valid for exactly one cycle, with rdata held. Return to IDLE.
- If read_en and write_en are both high, treat as a write. Bus signals: we=1, be=byte_en, wdata=wdata. Write responses pulse valid with rdata=0.
- Fetch is always a read: we=0, be=4'hF.
- Latency: request high at cycle N; bus_req from N+1; ack may arrive at N+1 at the earliest; valid at ack cycle+1. Minimum 3 cycles from request to valid, then 1 IDLE cycle before the next grant.
- Bus outputs are stable from grant to ack. bus_req drops the cycle after ack.
- Requests must be held until valid. A request withdrawn mid-transaction does not abort it: the bus cycle completes and valid still pulses. The requester ignores it.
- A requester that keeps its request high in RESP is re-arbitrated in the following IDLE. Exec drops read_en combinationally on valid, so back-to-back loads re-request normally.
- Fixed priority: continuous data requests may starve fetch. This is acceptable because exec holds the pipeline and therefore stops issuing.
- ack outside DATA/INSTR is ignored.

Optional Feature:
ARB_TIMEOUT_EN: adds an 8-bit (clog2 of TIMEOUT_CYCLES+1) cycle counter in DATA/INSTR, cleared on grant.
- If no ack arrives within TIMEOUT_CYCLES cycles: drop bus_req, go to RESP with rdata=0, pulse arb_err_out together with valid.
- Without the macro: no counter, the FSM waits indefinitely, and arb_err_out is constant 0.

Decomposition:
- Shared package/defines header: FSM state encodings (ARB_IDLE, ARB_DATA, ARB_INSTR, ARB_RESP, 2-bit) and the full byte-enable constant 4'hF, placed alongside the existing core defines.
- No sub-module needed; the watchdog counter stays inline.

Test Plan:
- Fetch alone: i_req=1, addr=0x100, ack 2 cycles after bus_req with rdata=0x00500093 -> bus_addr=0x100, we=0, be=F; i_valid pulses once with 0x00500093.
- Simultaneous requests: d_read_en=1 at 0x2000 and i_req=1 at 0x104 in the same cycle -> data granted first; d_valid, then i granted after IDLE; i_valid follows.
- Store: d_write_en=1, addr=0x3004, wdata=0xDEADBEEF, be=4'b0011, immediate ack -> bus we=1, be=3; d_valid at ack+1 with rdata=0.
- Async reset: rst_n=0 while in DATA with bus_req=1 -> all outputs 0 immediately; after release, a fresh fetch completes normally.
- Back-to-back loads: exec drops read_en on valid and re-raises it next cycle at 0x2004 -> second transaction granted; no lost or duplicated valid.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): never ack -> bus_req drops after 4 cycles; d_valid and arb_err_out pulse together; rdata=0.
